// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state encoding and command decode for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_ID,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Map a received opcode to the state that serves it.
    function automatic state_t decode_cmd(input logic [7:0] op);
        case (op)
            OP_READ: return ST_ADDR;
            OP_RDID: return ST_ID;
            OP_RDSR: return ST_STATUS;
            default: return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection on the synchronized value.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) flash responder: READ (0x03) streams bytes from a backing
// memory, RDID (0x9F) returns the JEDEC ID, RDSR (0x05) returns a status byte.
// All SPI pins are oversampled by the system clock.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        mem_rd_en,
    output logic [23:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        busy
);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sck_sync, w_sck_rise_raw, w_sck_fall_raw;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_sck_rise, w_sck_fall;
    logic w_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .i_async(spi_cs),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .i_async(spi_sck),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise_raw), .o_fall(w_sck_fall_raw)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .i_async(spi_mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sck_sync, w_mosi_rise, w_mosi_fall};

    // A cs release seen in the same clock as an sck edge discards the edge.
    assign w_sck_rise = w_sck_rise_raw & ~w_cs_rise;
    assign w_sck_fall = w_sck_fall_raw & ~w_cs_rise;

    state_t       r_state, w_state_next;
    logic [4:0]   r_bit_cnt;
    logic [22:0]  r_sh_in;
    logic [7:0]   r_tx;
    logic [2:0]   r_out_cnt;
    logic [1:0]   r_byte_idx;
    logic [7:0]   r_rdbuf;
    logic         r_rd_en, r_rd_en_d;
    logic [23:0]  r_rd_addr;
    logic         r_miso, r_oe;
    logic [1:0]   r_settle;
    logic         r_armed;
    logic [7:0]   w_cmd;
    logic [23:0]  w_addr;
    logic [7:0]   w_byte;
    logic         w_tx_state;

    assign w_cmd  = {r_sh_in[6:0], w_mosi};
    assign w_addr = {r_sh_in, w_mosi};

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; cs release returns to IDLE from anywhere.
    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall && r_armed) w_state_next = ST_CMD;
                ST_CMD:  if (w_sck_rise && r_bit_cnt == 5'd7) w_state_next = decode_cmd(w_cmd);
                ST_ADDR: if (w_sck_rise && r_bit_cnt == 5'd23) w_state_next = ST_READ;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Output decode: which states transmit, and the next byte to transmit.
    always_comb begin
        w_tx_state = 1'b0;
        w_byte     = 8'hFF;
        case (r_state)
            ST_READ: begin
                w_tx_state = 1'b1;
                w_byte     = r_rdbuf;
            end
            ST_ID: begin
                w_tx_state = 1'b1;
                case (r_byte_idx)
                    2'd0:    w_byte = JEDEC_ID[23:16];
                    2'd1:    w_byte = JEDEC_ID[15:8];
                    2'd2:    w_byte = JEDEC_ID[7:0];
                    default: w_byte = 8'hFF;
                endcase
            end
            ST_STATUS: begin
                w_tx_state = 1'b1;
                w_byte     = STATUS_BYTE;
            end
            default: begin
                w_tx_state = 1'b0;
                w_byte     = 8'hFF;
            end
        endcase
    end

    // Datapath: bit shifting, memory prefetch and MISO drive.
    // r_armed blocks a cs falling edge that only appears because the
    // synchronizer restarts from idle after reset while cs is already low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bit_cnt  <= '0;
            r_sh_in    <= '0;
            r_tx       <= '0;
            r_out_cnt  <= '0;
            r_byte_idx <= '0;
            r_rdbuf    <= '0;
            r_rd_en    <= 1'b0;
            r_rd_en_d  <= 1'b0;
            r_rd_addr  <= '0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_settle   <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_rd_en   <= 1'b0;
            r_rd_en_d <= r_rd_en;
            if (r_rd_en_d) r_rdbuf <= mem_rd_data;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            else if (w_cs_sync)   r_armed  <= 1'b1;

            if (w_cs_rise || r_state == ST_IDLE) begin
                r_bit_cnt  <= '0;
                r_out_cnt  <= '0;
                r_byte_idx <= '0;
                r_oe       <= 1'b0;
                r_miso     <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD: if (w_sck_rise) begin
                        r_sh_in   <= {r_sh_in[21:0], w_mosi};
                        r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                    end
                    ST_ADDR: if (w_sck_rise) begin
                        r_sh_in <= {r_sh_in[21:0], w_mosi};
                        if (r_bit_cnt == 5'd23) begin
                            r_bit_cnt <= '0;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_addr;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    default: if (w_tx_state && w_sck_fall) begin
                        r_oe      <= 1'b1;
                        r_out_cnt <= r_out_cnt + 3'd1;
                        if (r_out_cnt == 3'd0) begin
                            // MSB of a fresh byte; in READ, fetch the one after it.
                            r_miso <= w_byte[7];
                            r_tx   <= {w_byte[6:0], 1'b0};
                            if (r_state == ST_READ) begin
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= r_rd_addr + 24'd1;
                            end
                            if (r_byte_idx != 2'd3) r_byte_idx <= r_byte_idx + 2'd1;
                        end else begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                endcase
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign busy        = ~w_cs_sync;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI mode-0 master, a backing memory and
// a byte-level model of what each command should return.
module tb_spi_flash_responder;

    localparam int H = 6;   // sck half period in system clocks

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_rd_en;
    logic [23:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    bit          mem_lin = 1'b1;
    logic [23:0] rd_q[$];
    bit          oe_seen;
    logic [7:0]  rx_buf [0:7];
    logic        oe_first;

    spi_flash_responder dut (
        .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_cs(spi_cs),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory contents: either address low byte, or a hash of the address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return mem_lin ? a[7:0] : (a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A);
    endfunction

    // Reference: k-th response byte of a command.
    function automatic logic [7:0] expect_byte(input logic [7:0] cmd, input logic [23:0] addr, input int k);
        logic [23:0] id;
        id = 24'hEF4018;
        case (cmd)
            8'h03:   return mem_byte(addr + 24'(k));
            8'h9F:   return (k < 3) ? id[23-8*k -: 8] : 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem_byte(mem_rd_addr);

    always @(negedge clock) begin
        if (spi_miso_oe === 1'b1) oe_seen = 1'b1;
        if (mem_rd_en === 1'b1) rd_q.push_back(mem_rd_addr);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx, output logic oe0);
        rx = 8'h00;
        oe0 = 1'b0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = tx[7-i];
            repeat (H) @(posedge clock);
            #1;
            rx = {rx[6:0], spi_miso};
            if (i == 0) oe0 = spi_miso_oe;
            spi_sck = 1'b1;
            repeat (H) @(posedge clock);
            #1;
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge clock); #1;
        spi_cs = 1'b0;
        repeat (H) @(posedge clock);
    endtask

    task automatic cs_high();
        repeat (H) @(posedge clock); #1;
        spi_cs = 1'b1;
        repeat (4*H) @(posedge clock); #1;
    endtask

    // Full transaction: command, address for READ, n response bytes.
    task automatic do_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n);
        logic [7:0] d;
        logic o;
        cs_low();
        rd_q.delete();
        oe_seen = 1'b0;
        spi_bits(cmd, 8, d, o);
        if (cmd == 8'h03) begin
            spi_bits(addr[23:16], 8, d, o);
            spi_bits(addr[15:8], 8, d, o);
            spi_bits(addr[7:0], 8, d, o);
        end
        for (int k = 0; k < 8; k++) rx_buf[k] = 8'h00;
        oe_first = 1'b0;
        for (int k = 0; k < n; k++) begin
            spi_bits(8'($urandom), 8, rx_buf[k], o);
            if (k == 0) oe_first = o;
        end
        cs_high();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clock);
        n_tests += 5;
        if (spi_miso !== 1'b0)     begin n_fail++; $display("FAIL reset miso: got %b want 0", spi_miso); end
        if (spi_miso_oe !== 1'b0)  begin n_fail++; $display("FAIL reset oe: got %b want 0", spi_miso_oe); end
        if (mem_rd_en !== 1'b0)    begin n_fail++; $display("FAIL reset rd_en: got %b want 0", mem_rd_en); end
        if (mem_rd_addr !== 24'h0) begin n_fail++; $display("FAIL reset rd_addr: got %h want 000000", mem_rd_addr); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (10) @(posedge clock);
    endtask

    task automatic test_rdid();
        logic [7:0] exp [0:3];
        exp[0] = 8'hEF; exp[1] = 8'h40; exp[2] = 8'h18; exp[3] = 8'hFF;
        do_txn(8'h9F, 24'h0, 4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rx_buf[k] !== exp[k]) begin n_fail++; $display("FAIL rdid byte%0d: got %h want %h", k, rx_buf[k], exp[k]); end
        end
        n_tests += 3;
        if (oe_first !== 1'b1) begin n_fail++; $display("FAIL rdid oe at first bit: got %b want 1", oe_first); end
        if (rd_q.size() != 0)  begin n_fail++; $display("FAIL rdid rd_en count: got %0d want 0", rd_q.size()); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL rdid busy after cs: got %b want 0", busy); end
    endtask

    task automatic test_read_linear();
        mem_lin = 1'b1;
        do_txn(8'h03, 24'h000010, 4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rx_buf[k] !== 8'h10 + 8'(k)) begin n_fail++; $display("FAIL read byte%0d: got %h want %h", k, rx_buf[k], 8'h10 + 8'(k)); end
        end
        // The fall closing the last byte already prefetches the following one.
        n_tests++;
        if (rd_q.size() < 5 || rd_q.size() > 6) begin n_fail++; $display("FAIL read rd_en count: got %0d want 5..6", rd_q.size()); end
        for (int k = 0; k < rd_q.size(); k++) begin
            n_tests++;
            if (rd_q[k] !== 24'h10 + 24'(k)) begin n_fail++; $display("FAIL read rd_addr%0d: got %h want %h", k, rd_q[k], 24'h10 + 24'(k)); end
        end
        n_tests++;
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL read oe after cs: got %b want 0", spi_miso_oe); end
    endtask

    task automatic test_read_wrap();
        mem_lin = 1'b1;
        do_txn(8'h03, 24'hFFFFFF, 2);
        n_tests += 4;
        if (rx_buf[0] !== 8'hFF) begin n_fail++; $display("FAIL wrap byte0: got %h want ff", rx_buf[0]); end
        if (rx_buf[1] !== 8'h00) begin n_fail++; $display("FAIL wrap byte1: got %h want 00", rx_buf[1]); end
        if (rd_q.size() < 2) begin
            n_fail++; $display("FAIL wrap rd_en count: got %0d want >=2", rd_q.size());
            n_fail++; $display("FAIL wrap addresses missing");
        end else begin
            if (rd_q[0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL wrap rd_addr0: got %h want ffffff", rd_q[0]); end
            if (rd_q[1] !== 24'h000000) begin n_fail++; $display("FAIL wrap rd_addr1: got %h want 000000", rd_q[1]); end
        end
    endtask

    task automatic test_ignore();
        do_txn(8'hAB, 24'h0, 2);
        n_tests += 2;
        if (oe_seen)          begin n_fail++; $display("FAIL ignore oe: got 1 want 0"); end
        if (rd_q.size() != 0) begin n_fail++; $display("FAIL ignore rd_en count: got %0d want 0", rd_q.size()); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic o;
        cs_low();
        rd_q.delete();
        oe_seen = 1'b0;
        spi_bits(8'h03, 8, d, o);
        spi_bits(8'h12, 8, d, o);
        spi_bits(8'h30, 4, d, o);
        cs_high();
        n_tests += 4;
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort oe: got %b want 0", spi_miso_oe); end
        if (rd_q.size() != 0)     begin n_fail++; $display("FAIL abort rd_en count: got %0d want 0", rd_q.size()); end
        if (oe_seen)              begin n_fail++; $display("FAIL abort oe seen: got 1 want 0"); end
        do_txn(8'h05, 24'h0, 2);
        n_tests += 3;
        if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL status byte0: got %h want 00", rx_buf[0]); end
        if (rx_buf[1] !== 8'h00) begin n_fail++; $display("FAIL status byte1: got %h want 00", rx_buf[1]); end
        if (oe_first !== 1'b1)   begin n_fail++; $display("FAIL status oe at first bit: got %b want 1", oe_first); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, r0, r1;
        logic o;
        logic [23:0] a;
        mem_lin = 1'b0;
        a = 24'($urandom);
        cs_low();
        spi_bits(8'h03, 8, d, o);
        spi_bits(a[23:16], 8, d, o);
        spi_bits(a[15:8], 8, d, o);
        spi_bits(a[7:0], 8, d, o);
        spi_bits(8'h00, 8, r0, o);
        spi_bits(8'h00, 4, d, o);
        n_tests++;
        if (r0 !== mem_byte(a)) begin n_fail++; $display("FAIL midreset byte0: got %h want %h", r0, mem_byte(a)); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests += 5;
        if (spi_miso !== 1'b0)     begin n_fail++; $display("FAIL midreset miso: got %b want 0", spi_miso); end
        if (spi_miso_oe !== 1'b0)  begin n_fail++; $display("FAIL midreset oe: got %b want 0", spi_miso_oe); end
        if (mem_rd_en !== 1'b0)    begin n_fail++; $display("FAIL midreset rd_en: got %b want 0", mem_rd_en); end
        if (mem_rd_addr !== 24'h0) begin n_fail++; $display("FAIL midreset rd_addr: got %h want 000000", mem_rd_addr); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL midreset busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        rd_q.delete();
        oe_seen = 1'b0;
        // cs still low: the block must stay silent.
        spi_bits(8'h9F, 8, d, o);
        spi_bits(8'h00, 8, r1, o);
        n_tests += 3;
        if (oe_seen)          begin n_fail++; $display("FAIL postreset oe: got 1 want 0"); end
        if (rd_q.size() != 0) begin n_fail++; $display("FAIL postreset rd_en count: got %0d want 0", rd_q.size()); end
        if (r1 !== 8'h00)     begin n_fail++; $display("FAIL postreset miso byte: got %h want 00", r1); end
        cs_high();
        do_txn(8'h9F, 24'h0, 1);
        n_tests++;
        if (rx_buf[0] !== 8'hEF) begin n_fail++; $display("FAIL postreset rdid: got %h want ef", rx_buf[0]); end
    endtask

    task automatic test_random();
        logic [7:0] cmd, exp;
        logic [23:0] a;
        int n, kind;
        mem_lin = 1'b0;
        for (int t = 0; t < 12; t++) begin
            kind = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 5));
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
            case (kind)
                0: cmd = 8'h03;
                1: cmd = 8'h9F;
                2: cmd = 8'h05;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'h03 || cmd == 8'h9F || cmd == 8'h05) cmd = 8'($urandom);
                end
            endcase
            do_txn(cmd, a, n);
            if (kind == 3) begin
                n_tests += 2;
                if (oe_seen)          begin n_fail++; $display("FAIL rand%0d ignore %h oe: got 1 want 0", t, cmd); end
                if (rd_q.size() != 0) begin n_fail++; $display("FAIL rand%0d ignore %h rd_en: got %0d want 0", t, cmd, rd_q.size()); end
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp = expect_byte(cmd, a, k);
                    n_tests++;
                    if (rx_buf[k] !== exp) begin n_fail++; $display("FAIL rand%0d cmd %h addr %h byte%0d: got %h want %h", t, cmd, a, k, rx_buf[k], exp); end
                end
                n_tests++;
                if (kind == 0) begin
                    if (rd_q.size() < n + 1 || rd_q.size() > n + 2 || rd_q[0] !== a || rd_q[rd_q.size()-1] !== a + 24'(rd_q.size() - 1)) begin
                        n_fail++; $display("FAIL rand%0d read prefetch: count %0d first %h", t, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 24'hx);
                    end
                end else if (rd_q.size() != 0) begin
                    n_fail++; $display("FAIL rand%0d cmd %h rd_en: got %0d want 0", t, cmd, rd_q.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rdid();
        test_read_linear();
        test_read_wrap();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
